// File: rtl/sort_32x8b_stream_ctrl.sv
// Stream-side sequencer for the bitonic sorter: gathers one frame, hands it to the sorter,
// waits out the sorter latency, then streams the first len sorted elements back out.
module sort_32x8b_stream_ctrl #(
    parameter int            N        = 32,
    parameter int            W        = 8,
    parameter int            SORT_LAT = 0,
    parameter logic [W-1:0]  PAD      = {W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic             s_last,
    output logic [N*W-1:0]   srt_data_o,
    output logic             srt_start_o,
    input  logic [N*W-1:0]   srt_data_i,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             m_last,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int IDX_W = $clog2(N);
    localparam int LEN_W = IDX_W + 1;
    localparam int LAT_W = (SORT_LAT > 0) ? $clog2(SORT_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [N*W-1:0]     buf_q, buf_d;
    logic [N*W-1:0]     res_q, res_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               s_ready_q, s_ready_d;
    logic               srt_start_q, srt_start_d;
    logic               m_valid_q, m_valid_d;
    logic [W-1:0]       m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic               busy_q, busy_d;

    // Next-state logic for the frame sequencer and its datapath registers
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        len_d       = len_q;
        lat_d       = lat_q;
        buf_d       = buf_q;
        res_d       = res_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_FILL: begin
                if (s_valid && s_ready_q) begin
                    buf_d[int'(wr_idx_q)*W +: W] = s_data;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    // A full buffer ends the frame even without s_last
                    if (s_last || (wr_idx_q == IDX_W'(N - 1))) begin
                        len_d   = {1'b0, wr_idx_q} + LEN_W'(1);
                        lat_d   = '0;
                        state_d = ST_SORT;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_SORT: begin
                if (lat_q == LAT_W'(SORT_LAT)) begin
                    res_d    = srt_data_i;
                    rd_idx_d = '0;
                    state_d  = ST_DRAIN;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (m_valid_q && m_ready) begin
                    if (m_last_q) begin
                        buf_d       = {N{PAD}};
                        wr_idx_d    = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = ST_FILL;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Output registers are derived from next state so every port is a flop
    always_comb begin
        s_ready_d   = (state_d == ST_FILL);
        busy_d      = (state_d == ST_SORT) || (state_d == ST_DRAIN);
        srt_start_d = (state_q == ST_FILL) && (state_d == ST_SORT);
        m_valid_d   = (state_d == ST_DRAIN);
        if (state_d == ST_DRAIN) begin
            m_data_d = res_d[int'(rd_idx_d)*W +: W];
            m_last_d = ({1'b0, rd_idx_d} == (len_d - LEN_W'(1)));
        end else begin
            m_data_d = '0;
            m_last_d = 1'b0;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            len_q       <= '0;
            lat_q       <= '0;
            buf_q       <= {N{PAD}};
            res_q       <= '0;
            frame_cnt_q <= 16'd0;
            s_ready_q   <= 1'b1;
            srt_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            len_q       <= len_d;
            lat_q       <= lat_d;
            buf_q       <= buf_d;
            res_q       <= res_d;
            frame_cnt_q <= frame_cnt_d;
            s_ready_q   <= s_ready_d;
            srt_start_q <= srt_start_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign srt_data_o  = buf_q;
    assign srt_start_o = srt_start_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
